// File: rtl/array_pingpong_packer.sv
// array_pingpong_packer
// Double-buffered serial-to-array packer. Four consecutive words fill one bank
// while the other bank is offered downstream, so a continuous input stream
// yields one 4-element array every four cycles without stalling.

module array_pingpong_packer #(
    parameter int bits = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic [bits-1:0]      in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [3:0][bits-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_bank,
    output logic [1:0]           full_count
);

    // Two banks of four words each; element i holds the i-th word of the bank.
    logic [3:0][bits-1:0] r_bank [2];

    // Write pointer (bank + slot), read bank and per-bank full flags.
    logic       r_wr_bank;
    logic [1:0] r_wr_idx;
    logic       r_rd_bank;
    logic [1:0] r_full;

    logic       w_accept;
    logic       w_drain;
    logic       w_fill_done;
    logic [1:0] w_full_next;

    // Handshakes are decoded from registered state plus the partner's strobe.
    // A write needs a non-full bank and a read needs a full one, so the two
    // sides can never touch the same bank in one cycle.
    assign in_ready    = ~r_full[r_wr_bank];
    assign out_valid   = r_full[r_rd_bank];
    assign out_data    = r_bank[r_rd_bank];
    assign out_bank    = r_rd_bank;
    assign full_count  = {1'b0, r_full[0]} + {1'b0, r_full[1]};

    assign w_accept    = in_valid & in_ready;
    assign w_drain     = out_valid & out_ready;
    assign w_fill_done = w_accept & (r_wr_idx == 2'd3);

    // Next full flags: fill completion and drain always address different
    // banks, so both updates can be applied on the same edge.
    always_comb begin
        w_full_next = r_full;
        if (w_drain) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_fill_done) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

    // Pointer and flag state; clear flushes everything except the bank data
    // and takes priority over any handshake in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank <= 1'b0;
            r_wr_idx  <= 2'd0;
            r_rd_bank <= 1'b0;
            r_full    <= 2'b00;
        end else if (clear) begin
            r_wr_bank <= 1'b0;
            r_wr_idx  <= 2'd0;
            r_rd_bank <= 1'b0;
            r_full    <= 2'b00;
        end else begin
            r_full <= w_full_next;
            if (w_accept) begin
                r_wr_idx <= r_wr_idx + 2'd1;
            end
            if (w_fill_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_drain) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    // Bank storage: an accepted word lands in the current write slot; a word
    // accepted in the same cycle as clear is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_bank[b] <= '0;
            end
        end else if (w_accept && !clear) begin
            r_bank[r_wr_bank][r_wr_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_array_pingpong_packer.sv
// tb_array_pingpong_packer
// Directed test of the ping-pong packer with a scoreboard: every complete bank
// the stimulus builds is queued, and a monitor pops and compares each array
// the DUT hands off downstream.

module tb_array_pingpong_packer;

   typedef struct {
      logic             bank;
      logic [3:0][7:0]  data;
   } expItem_t;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic [7:0]       inData;
   logic             inValid;
   logic             inReady;
   logic [3:0][7:0]  outData;
   logic             outValid;
   logic             outReady;
   logic             outBank;
   logic [1:0]       fullCount;

   expItem_t         expQueue[$];
   int               assertCount = 0;
   int               failCount   = 0;

   array_pingpong_packer #(.bits(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_data    (inData),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .out_data   (outData),
      .out_valid  (outValid),
      .out_ready  (outReady),
      .out_bank   (outBank),
      .full_count (fullCount)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck design still ends with a report.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: counts it, and reports the name and both values on a miss.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Queue one expected array for the monitor.
   task automatic pushExpected(input logic bank, input logic [7:0] w0, input logic [7:0] w1,
                               input logic [7:0] w2, input logic [7:0] w3);
      expItem_t item;
      item.bank = bank;
      item.data = {w3, w2, w1, w0};
      expQueue.push_back(item);
   endtask

   // Drive one word for one cycle (called at posedge+1), checking in_ready at
   // mid-cycle, and return at the next posedge+1 with in_valid dropped.
   task automatic applyStimulus(input logic [7:0] word, input logic expReady);
      inValid = 1'b1;
      inData  = word;
      @(negedge clk);
      checkOutput("in_ready_during_word", {31'd0, inReady}, {31'd0, expReady});
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: at each falling edge, an offered array that downstream is taking
   // must match the oldest queued expectation.
   initial begin
      expItem_t item;
      forever begin
         @(negedge clk);
         if (rst_n && outValid && outReady) begin
            if (expQueue.size() == 0) begin
               checkOutput("unexpected_output_array", outData, 32'hDEAD_BEEF);
            end else begin
               item = expQueue.pop_front();
               checkOutput("out_data", outData, item.data);
               checkOutput("out_bank", {31'd0, outBank}, {31'd0, item.bank});
            end
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      rst_n    = 1'b0;
      clear    = 1'b0;
      inData   = 8'h00;
      inValid  = 1'b0;
      outReady = 1'b0;

      // Reset state.
      #12;
      checkOutput("reset_in_ready",   {31'd0, inReady},  32'd1);
      checkOutput("reset_out_valid",  {31'd0, outValid}, 32'd0);
      checkOutput("reset_out_bank",   {31'd0, outBank},  32'd0);
      checkOutput("reset_full_count", {30'd0, fullCount}, 32'd0);
      checkOutput("reset_out_data",   outData, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First bank fills with downstream stalled.
      $display("[TB] fill bank 0 with out_ready low");
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      applyStimulus(8'h33, 1'b1);
      checkOutput("out_valid_before_4th", {31'd0, outValid}, 32'd0);
      applyStimulus(8'h44, 1'b1);
      pushExpected(1'b0, 8'h11, 8'h22, 8'h33, 8'h44);
      checkOutput("out_valid_after_4th", {31'd0, outValid}, 32'd1);
      checkOutput("bank0_out_bank",      {31'd0, outBank},  32'd0);
      checkOutput("bank0_full_count",    {30'd0, fullCount}, 32'd1);
      checkOutput("bank0_out_data",      outData, 32'h4433_2211);

      // Second bank fills; both full so the ninth word is refused.
      $display("[TB] fill bank 1, then both banks full");
      applyStimulus(8'h55, 1'b1);
      applyStimulus(8'h66, 1'b1);
      applyStimulus(8'h77, 1'b1);
      applyStimulus(8'h88, 1'b1);
      pushExpected(1'b1, 8'h55, 8'h66, 8'h77, 8'h88);
      checkOutput("both_full_count", {30'd0, fullCount}, 32'd2);
      applyStimulus(8'h99, 1'b0);
      checkOutput("both_full_count_after_99", {30'd0, fullCount}, 32'd2);

      // One-cycle drain pulse releases bank 0.
      outReady = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b0;
      checkOutput("after_drain_in_ready",   {31'd0, inReady},  32'd1);
      checkOutput("after_drain_out_bank",   {31'd0, outBank},  32'd1);
      checkOutput("after_drain_full_count", {30'd0, fullCount}, 32'd1);
      checkOutput("after_drain_out_valid",  {31'd0, outValid}, 32'd1);
      outReady = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("empty_full_count", {30'd0, fullCount}, 32'd0);

      // Continuous stream with downstream always ready.
      $display("[TB] back-to-back stream of 16 words");
      for (int a = 0; a < 4; a++) begin
         pushExpected(a[0], 8'(4*a+1), 8'(4*a+2), 8'(4*a+3), 8'(4*a+4));
      end
      for (int w = 1; w <= 16; w++) begin
         applyStimulus(8'(w), 1'b1);
      end
      idleCycles(3);
      checkOutput("stream_full_count", {30'd0, fullCount}, 32'd0);
      checkOutput("stream_queue_drained", expQueue.size(), 32'd0);

      // Clear discards the word offered alongside it and resets the pointers.
      $display("[TB] clear during a partial fill");
      applyStimulus(8'hA1, 1'b1);
      applyStimulus(8'hA2, 1'b1);
      clear = 1'b1;
      applyStimulus(8'hA3, 1'b1);
      clear = 1'b0;
      checkOutput("after_clear_full_count", {30'd0, fullCount}, 32'd0);
      pushExpected(1'b0, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
      applyStimulus(8'hB1, 1'b1);
      applyStimulus(8'hB2, 1'b1);
      applyStimulus(8'hB3, 1'b1);
      applyStimulus(8'hB4, 1'b1);
      idleCycles(3);
      checkOutput("clear_queue_drained", expQueue.size(), 32'd0);

      // Asynchronous reset in the middle of a cycle wipes full and partial banks.
      $display("[TB] asynchronous reset mid-operation");
      outReady = 1'b0;
      applyStimulus(8'hC1, 1'b1);
      applyStimulus(8'hC2, 1'b1);
      applyStimulus(8'hC3, 1'b1);
      applyStimulus(8'hC4, 1'b1);
      applyStimulus(8'hD1, 1'b1);
      applyStimulus(8'hD2, 1'b1);
      checkOutput("pre_reset_out_valid",  {31'd0, outValid}, 32'd1);
      checkOutput("pre_reset_full_count", {30'd0, fullCount}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset_out_valid",  {31'd0, outValid}, 32'd0);
      checkOutput("async_reset_full_count", {30'd0, fullCount}, 32'd0);
      checkOutput("async_reset_in_ready",   {31'd0, inReady},  32'd1);
      checkOutput("async_reset_out_bank",   {31'd0, outBank},  32'd0);
      checkOutput("async_reset_out_data",   outData, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      outReady = 1'b1;
      pushExpected(1'b0, 8'hE1, 8'hE2, 8'hE3, 8'hE4);
      applyStimulus(8'hE1, 1'b1);
      applyStimulus(8'hE2, 1'b1);
      applyStimulus(8'hE3, 1'b1);
      applyStimulus(8'hE4, 1'b1);
      idleCycles(3);
      checkOutput("final_queue_drained", expQueue.size(), 32'd0);
      checkOutput("final_full_count", {30'd0, fullCount}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
